// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: groups the core-side load/store handshake and the RAM-side bus
// of dmem_ctrl into one bundle.
//   slave  modport : the controller view (core requests in, RAM strobes out)
//   master modport : the core/RAM environment view (directions mirrored)
// Core side : req, we, size, unsigned_ld, addr, wdata -> rdata, ready, err, busy
// RAM side  : mem_addr, mem_wdata, mem_be, mem_we, mem_re -> mem_rdata
interface dmem_ctrl_if #(
    parameter int unsigned DEPTH = 1024
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          unsigned_ld;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic          busy;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata, mem_rdata,
        output rdata, ready, err, busy, mem_addr, mem_wdata, mem_be, mem_we, mem_re
    );

    modport master (
        output req, we, size, unsigned_ld, addr, wdata, mem_rdata,
        input  rdata, ready, err, busy, mem_addr, mem_wdata, mem_be, mem_we, mem_re
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the core load/store port and a
// synchronous single-port RAM with WAIT_STATES extra read-latency cycles.
// Byte/half/word accesses with byte enables, sign/zero-extended loads, and
// misalignment / out-of-range / reserved-size error reporting.
// Ports:
//   CLK, RESET_N : clock (rising edge), asynchronous active-low reset
//   bus          : dmem_ctrl_if.slave (core handshake + RAM bus), all outputs registered
//   rd_cnt, wr_cnt, err_cnt : 16-bit saturating completion counters, present
//                             only when DMEM_STATS_EN is defined
module dmem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    dmem_ctrl_if.slave  bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic [15:0] err_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StAccess, StWait, StCapt, StResp} state_t;

    state_t        state_q, state_d;
    logic [2:0]    wait_cnt_q, wait_cnt_d;
    logic          lat_we_q, lat_we_d;
    logic [1:0]    lat_size_q, lat_size_d;
    logic          lat_uns_q, lat_uns_d;
    logic [1:0]    lat_lane_q, lat_lane_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;

    logic [31:0]   off;
    logic          dec_err;
    logic [31:0]   shifted;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lat_we_d    = lat_we_q;
        lat_size_d  = lat_size_q;
        lat_uns_d   = lat_uns_q;
        lat_lane_d  = lat_lane_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        busy_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;

        off     = bus.addr - BASE_ADDR;
        dec_err = (bus.size == 2'b11)
                | ((bus.size == 2'b01) && bus.addr[0])
                | ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00))
                | ((off >> 2) >= DEPTH);

        // Half-word loads are aligned, so the byte-lane shift also serves halves.
        shifted = bus.mem_rdata >> {lat_lane_q, 3'b000};

        unique case (state_q)
            // The response cycle also accepts a new request (back-to-back).
            StIdle, StResp: begin
                state_d = StIdle;
                if (bus.req) begin
                    if (dec_err) begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = StAccess;
                        busy_d     = 1'b1;
                        lat_we_d   = bus.we;
                        lat_size_d = bus.size;
                        lat_uns_d  = bus.unsigned_ld;
                        lat_lane_d = bus.addr[1:0];
                        mem_addr_d = off[2 +: AW];
                        mem_we_d   = bus.we;
                        mem_re_d   = ~bus.we;
                        mem_be_d   = 4'b1111;
                        if (bus.we) begin
                            unique case (bus.size)
                                2'b00: begin
                                    mem_be_d    = 4'b0001 << bus.addr[1:0];
                                    mem_wdata_d = {4{bus.wdata[7:0]}};
                                end
                                2'b01: begin
                                    mem_be_d    = 4'b0011 << {bus.addr[1], 1'b0};
                                    mem_wdata_d = {2{bus.wdata[15:0]}};
                                end
                                default: mem_wdata_d = bus.wdata;
                            endcase
                        end
                    end
                end
            end
            StAccess: begin
                if (lat_we_q) begin
                    state_d = StResp;
                    ready_d = 1'b1;
                end else if (WAIT_STATES == 0) begin
                    state_d = StCapt;
                    busy_d  = 1'b1;
                end else begin
                    state_d    = StWait;
                    busy_d     = 1'b1;
                    wait_cnt_d = 3'(WAIT_STATES - 1);
                end
            end
            StWait: begin
                busy_d = 1'b1;
                if (wait_cnt_q == 3'd0) begin
                    state_d = StCapt;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            StCapt: begin
                state_d = StResp;
                ready_d = 1'b1;
                unique case (lat_size_q)
                    2'b00: rdata_d = lat_uns_q ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
                    2'b01: rdata_d = lat_uns_q ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
                    default: rdata_d = bus.mem_rdata;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 3'd0;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_uns_q   <= 1'b0;
            lat_lane_q  <= 2'b00;
            rdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_we_q    <= lat_we_d;
            lat_size_q  <= lat_size_d;
            lat_uns_q   <= lat_uns_d;
            lat_lane_q  <= lat_lane_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    // Counted on the edge that raises ready, so an aborted access never counts.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_cnt_q  <= 16'h0;
            wr_cnt_q  <= 16'h0;
            err_cnt_q <= 16'h0;
        end else begin
            if (state_q == StCapt && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (state_q == StAccess && lat_we_q && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (err_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven bench for dmem_ctrl (DEPTH=16, WAIT_STATES=2,
// BASE_ADDR=0) with a behavioural RAM and a scoreboard of expected completions.
module tb_dmem_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WS    = 2;
    localparam logic [31:0] BASE  = 32'h0;

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } vec_t;

    typedef struct {
        bit          is_st;
        bit          err;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    dmem_ctrl_if #(.DEPTH(DEPTH)) bus ();

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif

    dmem_ctrl #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS),
        .BASE_ADDR   (BASE)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .err_cnt (err_cnt)
`endif
    );

    // RAM: read data appears 1+WS cycles after mem_re is sampled, junk otherwise.
    logic [31:0] ram  [DEPTH];
    logic [31:0] pipe [WS+1];

    always @(posedge CLK) begin
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_be[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
        end
        pipe[0] <= bus.mem_re ? ram[bus.mem_addr] : 32'h5A5A_5A5A;
        for (int k = 1; k <= WS; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[WS];

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];
    bit   seen = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    int   m_rd = 0, m_wr = 0, m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard side: RAM strobes are matched to the oldest pending access,
    // ready pops it and compares the result.
    always @(negedge CLK) begin
        exp_t e;
        if (bus.mem_we && bus.mem_re) fail_now("both_strobes");
        if (bus.mem_we || bus.mem_re) begin
            if (sb.size() == 0 || seen) begin
                fail_now("extra_strobe");
            end else begin
                seen = 1'b1;
                chk("strobe_we", {31'h0, bus.mem_we}, {31'h0, sb[0].is_st});
                chk("mem_addr", {28'h0, bus.mem_addr}, sb[0].maddr);
                chk("mem_be", {28'h0, bus.mem_be}, {28'h0, sb[0].be});
                if (sb[0].is_st) chk("mem_wdata", bus.mem_wdata, sb[0].mwdata);
            end
        end
        if (bus.ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_ready");
            end else begin
                e = sb.pop_front();
                chk("err", {31'h0, bus.err}, {31'h0, e.err});
                chk("rdata", bus.rdata, e.rdata);
                chk("busy_at_ready", {31'h0, bus.busy}, 32'h0);
                chk("strobe_seen", {31'h0, seen}, {31'h0, !e.err});
                seen = 1'b0;
                if (e.err) m_err++;
                else if (e.is_st) m_wr++;
                else m_rd++;
            end
        end
        else if (bus.err) fail_now("err_without_ready");
    end

    function automatic vec_t mk(bit we, logic [1:0] size, bit uns, logic [31:0] addr,
                                logic [31:0] wdata, bit err, logic [31:0] rdata,
                                logic [3:0] be, logic [31:0] maddr, logic [31:0] mwdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.be = be; v.maddr = maddr; v.mwdata = mwdata;
        return v;
    endfunction

    function automatic int exp_lat(vec_t v);
        if (v.err) return 1;
        if (v.we) return 2;
        return 3 + int'(WS);
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.is_st  = v.we;
        e.err    = v.err;
        e.be     = v.be;
        e.maddr  = v.maddr;
        e.mwdata = v.mwdata;
        if (!v.we && !v.err) model_rdata = v.rdata;
        e.rdata  = model_rdata;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        bus.req         = 1'b1;
        bus.we          = v.we;
        bus.size        = v.size;
        bus.unsigned_ld = v.uns;
        bus.addr        = v.addr;
        bus.wdata       = v.wdata;
    endtask

    // Called just after edge 0; returns at the negedge of the ready cycle.
    task automatic wait_ready(input string name, input int lat);
        int n = 1;
        bit done = 1'b0;
        while (!done && n <= 20) begin
            @(negedge CLK);
            if (bus.ready) done = 1'b1;
            else begin
                if (n == 1) chk({name, "_busy"}, {31'h0, bus.busy}, 32'h1);
                n++;
            end
        end
        if (done) chk({name, "_latency"}, n, lat);
        else begin
            fail_now({name, "_timeout"});
            sb.delete();
            seen = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(negedge CLK);
        drive(v);
        push_exp(v);
        @(posedge CLK);
        #1;
        // Inputs are scrambled after edge 0; the access must use latched values.
        bus.req         = 1'b0;
        bus.we          = ~v.we;
        bus.size        = 2'($urandom);
        bus.unsigned_ld = ~v.uns;
        bus.addr        = $urandom;
        bus.wdata       = $urandom;
        wait_ready(name, exp_lat(v));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rdata"}, bus.rdata, 32'h0);
        chk({tag, "_ready"}, {31'h0, bus.ready}, 32'h0);
        chk({tag, "_err"}, {31'h0, bus.err}, 32'h0);
        chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, bus.mem_we}, 32'h0);
        chk({tag, "_mem_re"}, {31'h0, bus.mem_re}, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, bus.mem_be}, 32'h0);
        chk({tag, "_mem_addr"}, {28'h0, bus.mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask

    vec_t tbl [$];

    initial begin
        vec_t v;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.unsigned_ld = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (3) @(negedge CLK);
        chk_zero_outputs("reset");
        RESET_N = 1'b1;

        //            we size uns addr          wdata         err rdata         be       maddr mwdata
        tbl.push_back(mk(1, 2'd2, 0, 32'h8,        32'hDEADBEEF, 0, 32'h0,        4'b1111, 2,  32'hDEADBEEF));
        tbl.push_back(mk(1, 2'd0, 0, 32'h5,        32'h000000AB, 0, 32'h0,        4'b0010, 1,  32'hABABABAB));
        tbl.push_back(mk(0, 2'd0, 1, 32'h5,        32'h0,        0, 32'h000000AB, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(1, 2'd1, 0, 32'hE,        32'h1234CAFE, 0, 32'h0,        4'b1100, 3,  32'hCAFECAFE));
        tbl.push_back(mk(0, 2'd1, 0, 32'hE,        32'h0,        0, 32'hFFFFCAFE, 4'b1111, 3,  32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h4,        32'h80FF1234, 0, 32'h0,        4'b1111, 1,  32'h80FF1234));
        tbl.push_back(mk(0, 2'd0, 0, 32'h7,        32'h0,        0, 32'hFFFFFF80, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(0, 2'd0, 1, 32'h7,        32'h0,        0, 32'h00000080, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h6,        32'h0,        0, 32'hFFFF80FF, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(0, 2'd1, 1, 32'h6,        32'h0,        0, 32'h000080FF, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h4,        32'h0,        0, 32'h00000034, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h8,        32'h0,        0, 32'hDEADBEEF, 4'b1111, 2,  32'h0));
        tbl.push_back(mk(0, 2'd1, 1, 32'h4,        32'h0,        0, 32'h00001234, 4'b1111, 1,  32'h0));
        tbl.push_back(mk(0, 2'd0, 1, 32'h9,        32'h0,        0, 32'h000000BE, 4'b1111, 2,  32'h0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h2,        32'h0,        1, 32'h0,        4'b0000, 0,  32'h0));
        tbl.push_back(mk(1, 2'd1, 0, 32'h3,        32'h5555,     1, 32'h0,        4'b0000, 0,  32'h0));
        tbl.push_back(mk(0, 2'd3, 0, 32'h0,        32'h0,        1, 32'h0,        4'b0000, 0,  32'h0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h40,       32'h0,        1, 32'h0,        4'b0000, 0,  32'h0));
        tbl.push_back(mk(1, 2'd0, 0, 32'h3F,       32'h00000077, 0, 32'h0,        4'b1000, 15, 32'h77777777));
        tbl.push_back(mk(0, 2'd0, 1, 32'h3F,       32'h0,        0, 32'h00000077, 4'b1111, 15, 32'h0));
        tbl.push_back(mk(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0,        1, 32'h0,        4'b0000, 0,  32'h0));

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
            if (i == 1) chk("ram1_byte1", {24'h0, ram[1][15:8]}, 32'hAB);
        end

        // Reset while a load sits in WAIT: everything clears, no ready follows.
        v = mk(0, 2'd0, 0, 32'h7, 32'h0, 0, 32'hFFFFFF80, 4'b1111, 1, 32'h0);
        @(negedge CLK);
        drive(v);
        push_exp(v);
        @(posedge CLK);
        #1 bus.req = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET_N = 1'b0;
        #1 chk_zero_outputs("midreset");
        sb.delete();
        seen = 1'b0;
        model_rdata = 32'h0;
        m_rd = 0; m_wr = 0; m_err = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (8) @(negedge CLK);
        run_vec(mk(0, 2'd2, 0, 32'h8, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 2, 32'h0), "post_reset");

        // Back-to-back: req held high through the store's ready cycle.
        v = mk(1, 2'd2, 0, 32'h20, 32'h13579BDF, 0, 32'h0, 4'b1111, 8, 32'h13579BDF);
        @(negedge CLK);
        drive(v);
        push_exp(v);
        @(posedge CLK);
        #1;
        wait_ready("b2b_store", 2);
        v = mk(0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h13579BDF, 4'b1111, 8, 32'h0);
        drive(v);
        push_exp(v);
        @(posedge CLK);
        #1;
        chk("b2b_no_gap_busy", {31'h0, bus.busy}, 32'h1);
        chk("b2b_no_gap_re", {31'h0, bus.mem_re}, 32'h1);
        bus.req = 1'b0;
        wait_ready("b2b_load", 3 + int'(WS));

        repeat (2) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
`ifdef DMEM_STATS_EN
        chk("rd_cnt", {16'h0, rd_cnt}, m_rd);
        chk("wr_cnt", {16'h0, wr_cnt}, m_wr);
        chk("err_cnt", {16'h0, err_cnt}, m_err);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller between the core's load/store port and a synchronous single-port RAM. It replaces the direct core-to-RAM wiring with a req/ready handshake. Supports byte, half-word and word accesses with byte enables, plus sign/zero extension on loads. Also provides configurable RAM read wait states and range/alignment error detection.

Parameters:
DEPTH, 1024, RAM depth in 32-bit words; power of two, >= 2
WAIT_STATES, 0, extra RAM read-latency cycles, 0..7
BASE_ADDR, 32'h0, byte address of RAM word 0; word aligned

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
req  in  1  access request; sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
unsigned_ld  in  1  1=zero-extend load, 0=sign-extend
addr  in  32  byte address
wdata  in  32  store data, right-aligned
rdata  out  32  extended load result, held until next load completes
ready  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with ready: misaligned, out-of-range or size=11
busy  out  1  access in flight
mem_addr  out  $clog2(DEPTH)  RAM word address
mem_wdata  out  32  RAM write data, lane-replicated
mem_be  out  4  RAM byte enables
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_rdata  in  32  RAM read data, valid 1+WAIT_STATES cycles after mem_re sampled

Behaviour:
- Reset (async assert, sync-release by design): state IDLE; all outputs 0; wait counter 0; any in-flight access is dropped and never produces ready.
- Edge numbering: edge 0 = the edge where req=1 is sampled in IDLE. All outputs are registered.
- FSM: IDLE -> ACCESS -> (write) RESP; (read) WAIT -> CAPT -> RESP; RESP -> IDLE. A zero WAIT_STATES count skips WAIT.
- Decode at edge 0: off = addr - BASE_ADDR (32-bit modular subtraction).
  - Error if size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or off>>2 >= DEPTH.
  - On error: no RAM strobe; ready=err=1 for the cycle after edge 0; rdata unchanged; state stays IDLE.
- ACCESS (cycle after edge 0): mem_addr=off[2+:$clog2(DEPTH)]; mem_we=we or mem_re=~we, exactly one cycle.
  - Store, byte: mem_be=4'b0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - Store, half: mem_be=4'b0011<<{addr[1],1'b0}; mem_wdata={2{wdata[15:0]}}.
  - Store, word: mem_be=4'b1111; mem_wdata=wdata.
  - Load: mem_be=4'b1111.
- Write: ready=1 in the cycle after edge 1.
- Read: after WAIT_STATES wait cycles, mem_rdata is sampled at edge 2+WAIT_STATES.
  - Lane select uses the latched addr[1:0]; extension per latched unsigned_ld.
  - rdata and ready=1 are updated at that edge.
- busy=1 from edge 0 up to, not including, the ready cycle. busy=0 and ready=1 coincide, so req may be accepted during the ready cycle (back-to-back).
- req outside IDLE is ignored; the core holds off until ready. addr/we/size/wdata/unsigned_ld are latched at edge 0, so later input changes have no effect.
- mem_we and mem_re are never both 1. Outside ACCESS, mem_* strobes are 0 and mem_addr/mem_be/mem_wdata hold their last value.

Optional Feature:
DMEM_STATS_EN defined:
- Adds outputs rd_cnt, wr_cnt, err_cnt, each 16 bits.
- Counters increment on each completed load, store and error respectively, saturate at 16'hFFFF, and clear on reset.

DMEM_STATS_EN undefined:
- The ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Store word, addr=0x8, wdata=0xDEADBEEF -> ACCESS cycle shows mem_addr=2, mem_be=1111, mem_we=1; ready=1 after edge 1, err=0.
- Store byte, addr=0x5, wdata=0x000000AB -> mem_addr=1, mem_be=0010, mem_wdata=0xABABABAB; RAM word 1 byte 1 becomes 0xAB.
- WAIT_STATES=2, RAM word 1 = 0x80FF1234:
  - load byte signed at 0x7 -> rdata=0xFFFFFF80, ready after edge 4.
  - load byte unsigned at 0x7 -> 0x00000080.
  - load half signed at 0x6 -> 0xFFFF80FF.
- Load word at 0x2, store half at 0x3, size=11, and access at BASE_ADDR+4*DEPTH -> each gives ready=err=1 after edge 0; no mem_we/mem_re pulse; rdata unchanged.
- RESET_N low during WAIT of a load -> all outputs 0 immediately; after release no ready pulse, and the next req is serviced normally.
- Back-to-back store then load, with req held high through the ready cycle -> second access issued with no idle cycle between; both complete with correct data.
